// File: rtl/mod_seq_ctrl.sv
// mod_seq_ctrl: steps a counter through a programmable schedule of moduli (e.g. mod4, mod5, ...).
// Define MODSEQ_PAUSE_EN to add the pause input and the PAUSE state.
module mod_seq_ctrl #(
   parameter int CW    = 3,
   parameter int AW    = 2,
   parameter int RPT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [CW-1:0]    cfg_term,
   input  logic [AW-1:0]    last_slot,
   input  logic [RPT_W-1:0] repeat_n,
   input  logic             start,
   input  logic             stop,
`ifdef MODSEQ_PAUSE_EN
   input  logic             pause,
`endif
   output logic [CW-1:0]    count,
   output logic [AW-1:0]    slot,
   output logic             wrap,
   output logic             busy,
   output logic             done
);
   localparam int DEPTH = 1 << AW;
   localparam logic [CW-1:0] TERM_EVEN = CW'(3);
   localparam logic [CW-1:0] TERM_ODD  = CW'(4);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1
`ifdef MODSEQ_PAUSE_EN
      , ST_PAUSE = 2'd2
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [AW-1:0]    slot_q, slot_d;
   logic [RPT_W-1:0] pass_q, pass_d;
   logic [AW-1:0]    last_q, last_d;
   logic [RPT_W-1:0] rep_q, rep_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CW-1:0]    term_q [DEPTH];
   logic [CW-1:0]    term_d [DEPTH];
   logic [RPT_W-1:0] pass_inc;
   logic             wrap_c;

   assign wrap_c   = (state_q == ST_RUN) && (count_q == term_q[slot_q]);
   assign pass_inc = pass_q + 1'b1;

   always_comb begin
      // NOTE: every _d starts from its held value so no branch below can infer a latch.
      state_d = state_q;
      count_d = count_q;
      slot_d  = slot_q;
      pass_d  = pass_q;
      last_d  = last_q;
      rep_d   = rep_q;
      term_d  = term_q;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            count_d = '0;
            slot_d  = '0;
            pass_d  = '0;
            // The table only changes while idle, so a running schedule is never disturbed.
            if (cfg_we) term_d[cfg_addr] = cfg_term;
            if (start && !stop) begin
               state_d = ST_RUN;
               last_d  = last_slot;
               rep_d   = repeat_n;
            end
         end

         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
               slot_d  = '0;
               pass_d  = '0;
            end else begin
               if (wrap_c) begin
                  count_d = '0;
                  if (slot_q != last_q) begin
                     slot_d = slot_q + 1'b1;
                  end else begin
                     slot_d = '0;
                     pass_d = pass_inc;
                  end
               end else begin
                  count_d = count_q + 1'b1;
               end

               // Completion wins over a pause request on the same edge.
               if (wrap_c && (slot_q == last_q) && (rep_q != '0) && (pass_inc == rep_q)) begin
                  state_d = ST_IDLE;
                  pass_d  = '0;
                  done_d  = 1'b1;
               end
`ifdef MODSEQ_PAUSE_EN
               else if (pause) begin
                  state_d = ST_PAUSE;
               end
`endif
            end
         end

`ifdef MODSEQ_PAUSE_EN
         ST_PAUSE: begin
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
               slot_d  = '0;
               pass_d  = '0;
            end else if (!pause) begin
               state_d = ST_RUN;
            end
         end
`endif

         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // NOTE: the schedule table is reset like any other state so a fresh part runs mod4/mod5 unconfigured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         slot_q  <= '0;
         pass_q  <= '0;
         last_q  <= AW'(1);
         rep_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            term_q[i] <= (i % 2 == 0) ? TERM_EVEN : TERM_ODD;
         end
      end else begin
         // NOTE: non-blocking updates so every register samples the same pre-edge values.
         state_q <= state_d;
         count_q <= count_d;
         slot_q  <= slot_d;
         pass_q  <= pass_d;
         last_q  <= last_d;
         rep_q   <= rep_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         term_q  <= term_d;
      end
   end

   assign count = count_q;
   assign slot  = slot_q;
   assign wrap  = wrap_c;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Directed bench for mod_seq_ctrl; outputs are packed as {count,slot,wrap,busy,done} and sampled on negedge.
module tb_mod_seq_ctrl;
   localparam int CW    = 3;
   localparam int AW    = 2;
   localparam int RPT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_we;
   logic [AW-1:0]    cfg_addr;
   logic [CW-1:0]    cfg_term;
   logic [AW-1:0]    last_slot;
   logic [RPT_W-1:0] repeat_n;
   logic             start;
   logic             stop;
`ifdef MODSEQ_PAUSE_EN
   logic             pause;
`endif
   logic [CW-1:0]    count;
   logic [AW-1:0]    slot;
   logic             wrap;
   logic             busy;
   logic             done;

   int errors = 0;
   int checks = 0;

   mod_seq_ctrl #(.CW(CW), .AW(AW), .RPT_W(RPT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_term  (cfg_term),
      .last_slot (last_slot),
      .repeat_n  (repeat_n),
      .start     (start),
      .stop      (stop),
`ifdef MODSEQ_PAUSE_EN
      .pause     (pause),
`endif
      .count     (count),
      .slot      (slot),
      .wrap      (wrap),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pk(input int c, input int s, input bit w, input bit b, input bit d);
      logic [7:0] v;
      v = {c[2:0], s[1:0], w, b, d};
      return v;
   endfunction

   // Default table {3,4,...} with last_slot=1: cycle j of a 9-cycle pass.
   function automatic logic [7:0] dflt(input int j);
      if (j < 4) return pk(j, 0, j == 3, 1'b1, 1'b0);
      else       return pk(j - 4, 1, j == 8, 1'b1, 1'b0);
   endfunction

   task automatic test_reset();
      logic [7:0] obs;
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_term = '0;
      last_slot = '0; repeat_n = '0; start = 1'b0; stop = 1'b0;
`ifdef MODSEQ_PAUSE_EN
      pause = 1'b0;
`endif
      repeat (2) @(negedge clk);
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== 8'h00) begin
         errors++; $display("FAIL reset_hold: got %b want %b", obs, 8'h00);
      end
      rst = 1'b0;
      @(negedge clk);
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== 8'h00) begin
         errors++; $display("FAIL reset_release: got %b want %b", obs, 8'h00);
      end
   endtask

   task automatic test_default_schedule();
      logic [7:0] obs, exp;
      last_slot = 2'd1; repeat_n = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 18; i++) begin
         exp = dflt(i % 9);
         obs = {count, slot, wrap, busy, done};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL default_run cycle %0d: got %b want %b", i, obs, exp);
         end
         @(negedge clk);
      end
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== pk(0, 0, 0, 0, 1)) begin
         errors++; $display("FAIL default_done: got %b want %b", obs, pk(0, 0, 0, 0, 1));
      end
      @(negedge clk);
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== 8'h00) begin
         errors++; $display("FAIL default_done_pulse_width: got %b want %b", obs, 8'h00);
      end
   endtask

   task automatic test_programmed_schedule();
      logic [7:0] obs, exp;
      int         ec [13] = '{0, 1, 0, 1, 2, 0, 0, 1, 2, 3, 4, 5, 6};
      int         es [13] = '{0, 0, 1, 1, 1, 2, 3, 3, 3, 3, 3, 3, 3};
      bit         ew [13] = '{0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_term = 3'd2;
      @(negedge clk);
      cfg_addr = 2'd2; cfg_term = 3'd0;
      @(negedge clk);
      cfg_addr = 2'd3; cfg_term = 3'd6;
      @(negedge clk);
      // Slot 0 is written in the same cycle as start.
      cfg_addr = 2'd0; cfg_term = 3'd1;
      last_slot = 2'd3; repeat_n = 4'd1; start = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b0;
      for (int i = 0; i < 13; i++) begin
         exp = pk(ec[i], es[i], ew[i], 1'b1, 1'b0);
         obs = {count, slot, wrap, busy, done};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL prog_run cycle %0d: got %b want %b", i, obs, exp);
         end
         @(negedge clk);
      end
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== pk(0, 0, 0, 0, 1)) begin
         errors++; $display("FAIL prog_done: got %b want %b", obs, pk(0, 0, 0, 0, 1));
      end
      @(negedge clk);
   endtask

   task automatic test_stop();
      logic [7:0] obs, exp;
      int         ec [5] = '{0, 1, 0, 1, 2};
      int         es [5] = '{0, 0, 1, 1, 1};
      bit         ew [5] = '{0, 1, 0, 0, 1};
      // Table is {1,2,0,6}; repeat_n=0 runs past the end of the first pass.
      last_slot = 2'd1; repeat_n = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp = pk(ec[i % 5], es[i % 5], ew[i % 5], 1'b1, 1'b0);
         obs = {count, slot, wrap, busy, done};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL forever_run cycle %0d: got %b want %b", i, obs, exp);
         end
         if (i == 7) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         obs = {count, slot, wrap, busy, done};
         checks++;
         if (obs !== 8'h00) begin
            errors++; $display("FAIL stop_idle cycle %0d: got %b want %b", i, obs, 8'h00);
         end
         @(negedge clk);
      end

      // Stop coincident with the final wrap: no done pulse.
      last_slot = 2'd0; repeat_n = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== pk(0, 0, 0, 1, 0)) begin
         errors++; $display("FAIL stopwrap_c0: got %b want %b", obs, pk(0, 0, 0, 1, 0));
      end
      @(negedge clk);
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== pk(1, 0, 1, 1, 0)) begin
         errors++; $display("FAIL stopwrap_c1: got %b want %b", obs, pk(1, 0, 1, 1, 0));
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== 8'h00) begin
         errors++; $display("FAIL stopwrap_no_done: got %b want %b", obs, 8'h00);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic [7:0] obs, exp;
      int         ec [5] = '{0, 1, 0, 1, 2};
      int         es [5] = '{0, 0, 1, 1, 1};
      last_slot = 2'd1; repeat_n = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp = pk(ec[i], es[i], (i == 1) || (i == 4), 1'b1, 1'b0);
         obs = {count, slot, wrap, busy, done};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL prereset_run cycle %0d: got %b want %b", i, obs, exp);
         end
         if (i < 4) @(negedge clk);
      end
      // Mid-cycle at count=2, slot=1: outputs must clear without a clock edge.
      #2 rst = 1'b1;
      #1;
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== 8'h00) begin
         errors++; $display("FAIL async_reset: got %b want %b", obs, 8'h00);
      end
      @(negedge clk);
      rst = 1'b0;
      last_slot = 2'd1; repeat_n = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exp = dflt(i);
         obs = {count, slot, wrap, busy, done};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL postreset_table cycle %0d: got %b want %b", i, obs, exp);
         end
         @(negedge clk);
      end
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== pk(0, 0, 0, 0, 1)) begin
         errors++; $display("FAIL postreset_done: got %b want %b", obs, pk(0, 0, 0, 0, 1));
      end
      @(negedge clk);
   endtask

   task automatic test_busy_ignores();
      logic [7:0] obs, exp;
      last_slot = 2'd1; repeat_n = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exp = dflt(i);
         obs = {count, slot, wrap, busy, done};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL busy_cfg_run cycle %0d: got %b want %b", i, obs, exp);
         end
         cfg_we = (i < 8); cfg_addr = 2'd0; cfg_term = 3'd0;
         start = (i >= 2) && (i <= 4);
         @(negedge clk);
      end
      cfg_we = 1'b0; start = 1'b0;
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== pk(0, 0, 0, 0, 1)) begin
         errors++; $display("FAIL busy_cfg_done: got %b want %b", obs, pk(0, 0, 0, 0, 1));
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exp = dflt(i);
         obs = {count, slot, wrap, busy, done};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL old_term_run cycle %0d: got %b want %b", i, obs, exp);
         end
         @(negedge clk);
      end
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== pk(0, 0, 0, 0, 1)) begin
         errors++; $display("FAIL old_term_done: got %b want %b", obs, pk(0, 0, 0, 0, 1));
      end
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== 8'h00) begin
         errors++; $display("FAIL start_stop_idle: got %b want %b", obs, 8'h00);
      end
      @(negedge clk);
   endtask

`ifdef MODSEQ_PAUSE_EN
   task automatic test_pause();
      logic [7:0] obs, exp;
      int         j;
      last_slot = 2'd1; repeat_n = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i < 2)       j = i;
         else if (i <= 4) j = -1;
         else             j = i - 3;
         exp = (j < 0) ? pk(2, 0, 1'b0, 1'b1, 1'b0) : dflt(j);
         obs = {count, slot, wrap, busy, done};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL pause_run cycle %0d: got %b want %b", i, obs, exp);
         end
         pause = (i >= 1) && (i <= 3);
         @(negedge clk);
      end
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== pk(0, 0, 0, 0, 1)) begin
         errors++; $display("FAIL pause_done: got %b want %b", obs, pk(0, 0, 0, 0, 1));
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; pause = 1'b1;
      @(negedge clk);
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== pk(1, 0, 0, 1, 0)) begin
         errors++; $display("FAIL paused_hold: got %b want %b", obs, pk(1, 0, 0, 1, 0));
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0; pause = 1'b0;
      obs = {count, slot, wrap, busy, done};
      checks++;
      if (obs !== 8'h00) begin
         errors++; $display("FAIL pause_stop: got %b want %b", obs, 8'h00);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_default_schedule();
      test_programmed_schedule();
      test_stop();
      test_async_reset();
      test_busy_ignores();
`ifdef MODSEQ_PAUSE_EN
      test_pause();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
